// File: rtl/decoder_pkg.sv
// Shared constants and the one-hot helper for the scanning decoder family.
package decoder_pkg;

  localparam logic MODE_DIRECT = 1'b0;
  localparam logic MODE_SCAN   = 1'b1;
  localparam logic DIR_UP      = 1'b0;
  localparam logic DIR_DOWN    = 1'b1;

  // Widest decode supported by onehot(); callers cast the result down to OUT_W.
  localparam int MAX_SEL_W = 8;
  localparam int MAX_OUT_W = 2 ** MAX_SEL_W;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_DIRECT,
    ST_SCAN
  } state_e;

  function automatic logic [MAX_OUT_W-1:0] onehot(input logic [MAX_SEL_W-1:0] sel,
                                                  input logic act_low);
    logic [MAX_OUT_W-1:0] v;
    v      = '0;
    v[sel] = 1'b1;
    return act_low ? ~v : v;
  endfunction

endpackage

// File: rtl/decoder_scan_nm_scan_prescaler.sv
// Step-rate prescaler: tick fires whenever cnt has reached div, then cnt restarts.
module scan_prescaler #(
  parameter int DIV_W = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             run,
  input  logic             clr,
  input  logic [DIV_W-1:0] div,
  output logic             tick
);

  logic [DIV_W-1:0] cnt_q, cnt_d;

  // >= rather than == so a div lowered below the running count steps at once.
  assign tick = run && (cnt_q >= div);

  always_comb begin
    cnt_d = cnt_q;
    if (clr)       cnt_d = '0;
    else if (tick) cnt_d = '0;
    else if (run)  cnt_d = cnt_q + DIV_W'(1);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) cnt_q <= '0;
    else        cnt_q <= cnt_d;
  end

endmodule

// File: rtl/decoder_scan_nm.sv
// Registered N-to-2^N one-hot decoder with a direct-select mode and a
// prescaled up/down scanning mode for chasers and digit/row strobes.
module decoder_scan_nm
  import decoder_pkg::*;
#(
  parameter int  SEL_W   = 3,
  parameter int  DIV_W   = 16,
  parameter bit  ACT_LOW = 1'b0,
  localparam int OUT_W   = 2 ** SEL_W
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             en,
  input  logic             mode,
  input  logic             dir,
  input  logic [SEL_W-1:0] sel,
  input  logic             load,
  input  logic [DIV_W-1:0] div,
  output logic [OUT_W-1:0] out,
  output logic [SEL_W-1:0] idx,
  output logic             wrap
);

  localparam logic [OUT_W-1:0] OUT_OFF = {OUT_W{ACT_LOW}};

  state_e           st;
  logic             run, clr, tick, at_edge;
  logic [SEL_W-1:0] idx_q, idx_d;
  logic [OUT_W-1:0] out_q, out_d;
  logic             wrap_q, wrap_d;

  // Mode is not sticky: it is re-derived from en/mode every cycle.
  always_comb begin
    if (!en)                    st = ST_IDLE;
    else if (mode == MODE_SCAN) st = ST_SCAN;
    else                        st = ST_DIRECT;
  end

  assign run = (st == ST_SCAN);
  assign clr = (st == ST_DIRECT) || ((st == ST_SCAN) && load);

  scan_prescaler #(.DIV_W(DIV_W)) u_presc (
    .clk  (clk),
    .rst_n(rst_n),
    .run  (run),
    .clr  (clr),
    .div  (div),
    .tick (tick)
  );

  assign at_edge = (dir == DIR_UP) ? (idx_q == {SEL_W{1'b1}}) : (idx_q == '0);

  always_comb begin
    idx_d  = idx_q;
    wrap_d = 1'b0;
    unique case (st)
      ST_DIRECT: idx_d = sel;
      ST_SCAN: begin
        if (load) begin
          idx_d = sel;
        end else if (tick) begin
          idx_d  = (dir == DIR_UP) ? idx_q + SEL_W'(1) : idx_q - SEL_W'(1);
          wrap_d = at_edge;
        end
      end
      default: ;
    endcase
    out_d = (st == ST_IDLE) ? OUT_OFF
                            : OUT_W'(onehot(MAX_SEL_W'(idx_d), ACT_LOW));
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      idx_q  <= '0;
      out_q  <= OUT_OFF;
      wrap_q <= 1'b0;
    end else begin
      idx_q  <= idx_d;
      out_q  <= out_d;
      wrap_q <= wrap_d;
    end
  end

  assign out  = out_q;
  assign idx  = idx_q;
  assign wrap = wrap_q;

endmodule

// File: tb/tb_decoder_scan_nm.sv
// Directed scoreboard bench: active-high and active-low decoders driven in parallel.
module tb_decoder_scan_nm;

  logic        clk = 1'b0;
  logic        rst_n, en, mode, dir, load;
  logic [2:0]  sel;
  logic [15:0] div;
  logic [7:0]  out0, out1;
  logic [2:0]  idx0, idx1;
  logic        wrap0, wrap1;

  int checks   = 0;
  int failures = 0;

  typedef struct {
    string      tag;
    logic [7:0] o;
    logic [2:0] i;
    logic       w;
  } exp_t;

  exp_t sb[$];

  always #5 clk = ~clk;

  decoder_scan_nm #(.SEL_W(3), .DIV_W(16), .ACT_LOW(1'b0)) dut0 (
    .clk(clk), .rst_n(rst_n), .en(en), .mode(mode), .dir(dir), .sel(sel),
    .load(load), .div(div), .out(out0), .idx(idx0), .wrap(wrap0)
  );

  decoder_scan_nm #(.SEL_W(3), .DIV_W(16), .ACT_LOW(1'b1)) dut1 (
    .clk(clk), .rst_n(rst_n), .en(en), .mode(mode), .dir(dir), .sel(sel),
    .load(load), .div(div), .out(out1), .idx(idx1), .wrap(wrap1)
  );

  task automatic compare();
    exp_t e;
    e = sb.pop_front();
    checks++;
    assert (out0 === e.o) else begin
      failures++;
      $error("FAIL %s out: got %h want %h", e.tag, out0, e.o);
    end
    checks++;
    assert (idx0 === e.i) else begin
      failures++;
      $error("FAIL %s idx: got %0d want %0d", e.tag, idx0, e.i);
    end
    checks++;
    assert (wrap0 === e.w) else begin
      failures++;
      $error("FAIL %s wrap: got %b want %b", e.tag, wrap0, e.w);
    end
    checks++;
    assert (out1 === ~e.o) else begin
      failures++;
      $error("FAIL %s out_act_low: got %h want %h", e.tag, out1, ~e.o);
    end
    checks++;
    assert ({idx1, wrap1} === {e.i, e.w}) else begin
      failures++;
      $error("FAIL %s idx_wrap_act_low: got %0d/%b want %0d/%b", e.tag, idx1, wrap1, e.i, e.w);
    end
  endtask

  // Expectation for the state after the next rising edge.
  task automatic cyc(input string tag, input logic [7:0] o, input logic [2:0] i, input logic w);
    sb.push_back('{tag, o, i, w});
    @(posedge clk);
    #1;
    compare();
  endtask

  // Expectation for the current state, no clock edge involved.
  task automatic now(input string tag, input logic [7:0] o, input logic [2:0] i, input logic w);
    sb.push_back('{tag, o, i, w});
    compare();
  endtask

  initial begin
    rst_n = 1'b0; en = 1'b0; mode = 1'b0; dir = 1'b0;
    load  = 1'b0; sel = 3'd0; div = 16'd0;
    @(posedge clk); #1;
    now("reset", 8'h00, 3'd0, 1'b0);

    rst_n = 1'b1; en = 1'b1; sel = 3'd5;
    cyc("direct5", 8'h20, 3'd5, 1'b0);
    sel = 3'd0;
    cyc("direct0", 8'h01, 3'd0, 1'b0);

    // scan up from 6, div=2: step every 3 cycles, wrap on 7->0
    mode = 1'b1; load = 1'b1; sel = 3'd6; div = 16'd2;
    cyc("up_load6", 8'h40, 3'd6, 1'b0);
    load = 1'b0;
    cyc("up_hold6a", 8'h40, 3'd6, 1'b0);
    cyc("up_hold6b", 8'h40, 3'd6, 1'b0);
    cyc("up_step7", 8'h80, 3'd7, 1'b0);
    cyc("up_hold7a", 8'h80, 3'd7, 1'b0);
    cyc("up_hold7b", 8'h80, 3'd7, 1'b0);
    cyc("up_wrap0", 8'h01, 3'd0, 1'b1);
    cyc("up_after_wrap", 8'h01, 3'd0, 1'b0);

    // scan down, div=0: step every cycle, wrap on 0->7
    dir = 1'b1; load = 1'b1; sel = 3'd1; div = 16'd0;
    cyc("dn_load1", 8'h02, 3'd1, 1'b0);
    load = 1'b0;
    cyc("dn_step0", 8'h01, 3'd0, 1'b0);
    cyc("dn_wrap7", 8'h80, 3'd7, 1'b1);
    cyc("dn_step6", 8'h40, 3'd6, 1'b0);

    // load on the same cycle the prescaler fires
    dir = 1'b0; div = 16'd2;
    cyc("lt_cnt1", 8'h40, 3'd6, 1'b0);
    cyc("lt_cnt2", 8'h40, 3'd6, 1'b0);
    load = 1'b1; sel = 3'd3;
    cyc("lt_load3", 8'h08, 3'd3, 1'b0);
    load = 1'b0;
    cyc("lt_hold3a", 8'h08, 3'd3, 1'b0);
    cyc("lt_hold3b", 8'h08, 3'd3, 1'b0);
    cyc("lt_step4", 8'h10, 3'd4, 1'b0);

    // disable mid-scan with cnt=1; resume must keep that count
    cyc("en_cnt1", 8'h10, 3'd4, 1'b0);
    en = 1'b0;
    cyc("idle_a", 8'h00, 3'd4, 1'b0);
    cyc("idle_b", 8'h00, 3'd4, 1'b0);
    en = 1'b1;
    cyc("resume_cnt2", 8'h10, 3'd4, 1'b0);
    cyc("resume_step5", 8'h20, 3'd5, 1'b0);

    // div 9 -> 3 while cnt=7 steps on the next edge
    div = 16'd9;
    for (int k = 0; k < 7; k++) cyc("div9_hold", 8'h20, 3'd5, 1'b0);
    div = 16'd3;
    cyc("div_lowered_step", 8'h40, 3'd6, 1'b0);

    // direct sel=2 (active-low copy shows FB), then scan and async reset
    mode = 1'b0; sel = 3'd2;
    cyc("direct2", 8'h04, 3'd2, 1'b0);
    mode = 1'b1; div = 16'd0;
    cyc("to_scan_step3", 8'h08, 3'd3, 1'b0);
    #2 rst_n = 1'b0;
    #1;
    now("async_reset", 8'h00, 3'd0, 1'b0);
    rst_n = 1'b1;
    cyc("restart_step1", 8'h02, 3'd1, 1'b0);

    checks++;
    assert (sb.size() == 0) else begin
      failures++;
      $error("FAIL scoreboard_drain: got %0d left want 0", sb.size());
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/decoder_scan_nm.md
Name: decoder_scan_nm

Overview:
- Parametrised registered N-to-2^N one-hot decoder. Successor to the fixed combinational 3-to-8 decoder.
- Two modes:
  - Direct: registers the decode of an external select.
  - Scan: an internal index steps up or down at a programmable prescaled rate and wraps around. Used for LED chasers and digit/row scanning.
- Sits between control logic and one-hot-driven loads (LEDs, digit enables, row strobes).

Parameters:
- SEL_W, 3, select/index width; OUT_W = 2**SEL_W is a derived localparam, not overridable.
- DIV_W, 16, prescaler reload width.
- ACT_LOW, 0, 1 = active output bit is 0 and inactive level is all-ones; 0 = active bit is 1.

Ports:
- clk  input  1  system clock, rising edge.
- rst_n  input  1  asynchronous active-low reset.
- en  input  1  block enable.
- mode  input  1  0 = direct, 1 = scan.
- dir  input  1  scan direction, 0 = up, 1 = down.
- sel  input  SEL_W  direct-mode select; scan-mode load value.
- load  input  1  scan mode: load idx from sel (one-cycle pulse).
- div  input  DIV_W  prescaler terminal count; step period is div+1 cycles.
- out  output  OUT_W  registered one-hot decode of idx, bit i active iff idx==i, vector [OUT_W-1:0].
- idx  output  SEL_W  current index.
- wrap  output  1  one-cycle pulse on scan wrap-around.

Behaviour:
- Reset (async assert, sync deassert by clk domain):
  - idx=0, prescaler cnt=0, wrap=0.
  - out=inactive (all 0, or all 1 if ACT_LOW).
  - state=IDLE.
- States:
  - IDLE when en=0.
  - DIRECT when en=1 and mode=0.
  - SCAN when en=1 and mode=1.
  - State is re-evaluated every cycle from en/mode.
- IDLE:
  - idx and cnt hold; wrap=0.
  - out goes inactive on the next edge.
- DIRECT:
  - idx<=sel and out<=onehot(sel) on the same edge; latency 1 cycle from sel to out.
  - cnt held at 0; wrap=0.
- SCAN step rule:
  - Each cycle: if cnt>=div then step and cnt<=0, else cnt<=cnt+1.
  - The >= comparison makes lowering div mid-count step on the next cycle.
  - div=0 steps every cycle.
- Step direction:
  - dir=0: idx<=idx+1, modulo OUT_W.
  - dir=1: idx<=idx-1, modulo OUT_W.
  - out<=onehot(new idx) on the same edge.
- wrap:
  - Asserted for exactly the cycle in which out shows the wrapped value.
  - Up: step from OUT_W-1 to 0. Down: step from 0 to OUT_W-1.
- load:
  - Priority over step: idx<=sel, out<=onehot(sel), cnt<=0, wrap=0.
  - load is ignored in IDLE and DIRECT.
- Mode and enable transitions:
  - DIRECT->SCAN: scanning starts from the current idx with cnt=0. First step occurs div+1 cycles after entry.
  - SCAN->DIRECT: idx takes sel on the next edge.
  - IDLE->SCAN: resumes from the held idx and cnt.
- dir change: takes effect at the next step; cnt is not reset.
- out is always exactly one-hot (or one-cold) except in reset and IDLE. No glitch path: out is a register.
- Reset asserted mid-scan: all registers return to their reset values immediately. Scan restarts from idx=0.

Decomposition:
- Shared package decoder_pkg:
  - MODE_DIRECT=1'b0, MODE_SCAN=1'b1.
  - DIR_UP=1'b0, DIR_DOWN=1'b1.
  - Function onehot(sel, act_low) returning OUT_W bits.
- One natural sub-module, scan_prescaler (DIV_W):
  - Inputs: clk, rst_n, run, clr, div.
  - Output: tick, a one-cycle pulse when cnt>=div.
  - Top level owns idx, out and wrap.

Test Plan (SEL_W=3, DIV_W=16, ACT_LOW=0 unless stated):
- Reset/direct:
  - Stimulus: rst_n low -> out=8'h00, idx=0, wrap=0. Release, en=1, mode=0, sel=3'd5.
  - Response: next edge out=8'h20, idx=5. sel=3'd0 -> out=8'h01 one cycle later.
- Scan up with wrap:
  - Stimulus: mode=1, load with sel=6, div=2.
  - Response: out=8'h40, then steps every 3 cycles to 8'h80, then 8'h01 with wrap=1 for exactly one cycle.
- Scan down, div=0:
  - Stimulus: dir=1, load sel=1.
  - Response: out 8'h02, 8'h01, 8'h80 (wrap=1), 8'h40 on consecutive cycles.
- Simultaneous load and tick:
  - Stimulus: assert load with sel=3 on the cycle cnt==div.
  - Response: idx=3, out=8'h08, wrap=0, next step div+1 cycles later.
- Enable and div change:
  - en=0 mid-scan at idx=4 -> out=8'h00, idx holds 4. en=1 -> resumes from 4 with cnt held.
  - With cnt=7, reduce div from 9 to 3 -> step on the next cycle.
- ACT_LOW=1, async reset mid-scan:
  - direct sel=2 -> out=8'hFB.
  - Drop rst_n between edges -> out=8'hFF and idx=0 immediately, without waiting for a clock edge.
